// File: rtl/rom_stream_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rom_stream_pkg                                                     |
// | Shared widths, ROM depth and FSM state type for the ROM reader.    |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
package rom_stream_pkg;

   localparam int c_AW        = 4;
   localparam int c_DW        = 8;
   localparam int c_ROM_DEPTH = 1 << c_AW;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      DRAIN = 2'd2
   } state_t;

endpackage
`default_nettype wire

// File: rtl/stream_fifo2.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | stream_fifo2                                                       |
// | Small shift-register FIFO; entry 0 is the registered head.         |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module stream_fifo2 #(
   parameter int DW    = 8,
   parameter int DEPTH = 2,
   parameter int CW    = $clog2(DEPTH + 1)
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_push,
   input  logic [DW-1:0] i_data,
   input  logic          i_pop,
   output logic [DW-1:0] o_head,
   output logic [CW-1:0] o_count,
   output logic          o_full,
   output logic          o_empty
);

   logic [DW-1:0] r_mem [DEPTH];
   logic [CW-1:0] r_count;
   logic          w_pop;
   logic [CW-1:0] w_wr_idx;

   assign w_pop    = i_pop & ~o_empty;
   // When popping, the new byte lands one slot lower because everything shifts down.
   assign w_wr_idx = r_count - CW'(w_pop);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_count <= '0;
         for (int i = 0; i < DEPTH; i++) begin
            r_mem[i] <= '0;
         end
      end else begin
         for (int i = 0; i < DEPTH; i++) begin
            if (i_push && (CW'(i) == w_wr_idx)) begin
               r_mem[i] <= i_data;
            end else if (w_pop && (i < DEPTH - 1)) begin
               r_mem[i] <= r_mem[(i < DEPTH - 1) ? i + 1 : i];
            end
         end
         r_count <= r_count + CW'(i_push) - CW'(w_pop);
      end
   end

   assign o_head  = r_mem[0];
   assign o_count = r_count;
   assign o_full  = (r_count == CW'(DEPTH));
   assign o_empty = (r_count == '0);

endmodule
`default_nettype wire

// File: rtl/rom_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | rom_stream_reader                                                  |
// | Walks a ROM address range and streams the bytes with backpressure. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module rom_stream_reader
   import rom_stream_pkg::*;
#(
   parameter int AW         = c_AW,
   parameter int DW         = c_DW,
   parameter int FIFO_DEPTH = 2
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          start,
   input  logic [AW-1:0] base,
   input  logic [AW:0]   len,
   output logic          busy,
   output logic          done,
   output logic          rom_re,
   output logic [AW-1:0] rom_addr,
   input  logic [DW-1:0] rom_data,
   output logic          m_valid,
   output logic [DW-1:0] m_data,
   input  logic          m_ready
);

   localparam int CW = $clog2(FIFO_DEPTH + 1);

   state_t        r_state;
   logic          r_busy;
   logic          r_done;
   logic          r_inflight;
   logic [AW-1:0] r_addr;
   logic [AW:0]   r_rem;

   logic [CW-1:0] w_count;
   logic          w_full;
   logic          w_empty;
   logic [DW-1:0] w_head;
   logic          w_pop;
   logic          w_push;
   logic [CW:0]   w_occ;
   logic          w_rom_re;

   assign w_pop  = ~w_empty & m_ready;
   assign w_push = r_inflight & (~w_full | w_pop);

   // Slots already claimed after this cycle's pop; a new read needs one free.
   assign w_occ    = {1'b0, w_count} + (CW + 1)'(r_inflight) - (CW + 1)'(w_pop);
   assign w_rom_re = (r_state == RUN) && (r_rem != '0) &&
                     (w_occ < (CW + 1)'(FIFO_DEPTH));

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state    <= IDLE;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
         r_inflight <= 1'b0;
         r_addr     <= '0;
         r_rem      <= '0;
      end else begin
         r_done     <= 1'b0;
         r_inflight <= w_rom_re;
         if (w_rom_re) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 1'b1;
         end
         case (r_state)
            IDLE: begin
               if (start) begin
                  if (len == '0) begin
                     r_done <= 1'b1;
                  end else begin
                     r_addr  <= base;
                     r_rem   <= len;
                     r_busy  <= 1'b1;
                     r_state <= RUN;
                  end
               end
            end
            RUN: begin
               if (w_rom_re && (r_rem == (AW + 1)'(1))) begin
                  r_state <= DRAIN;
               end
            end
            DRAIN: begin
               if (!r_inflight && w_empty) begin
                  r_done  <= 1'b1;
                  r_busy  <= 1'b0;
                  r_state <= IDLE;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   stream_fifo2 #(
      .DW   (DW),
      .DEPTH(FIFO_DEPTH),
      .CW   (CW)
   ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push),
      .i_data (rom_data),
      .i_pop  (w_pop),
      .o_head (w_head),
      .o_count(w_count),
      .o_full (w_full),
      .o_empty(w_empty)
   );

   assign busy     = r_busy;
   assign done     = r_done;
   assign rom_re   = w_rom_re;
   assign rom_addr = r_addr;
   assign m_valid  = ~w_empty;
   assign m_data   = w_head;

endmodule
`default_nettype wire

// File: tb/tb_rom_stream_reader.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | tb_rom_stream_reader                                               |
// | Table-driven and randomized transfers against a queue-based model. |
// | Revision: 1.0                                                      |
// +--------------------------------------------------------------------+
module tb_rom_stream_reader;
   import rom_stream_pkg::*;

   localparam int AW         = c_AW;
   localparam int DW         = c_DW;
   localparam int FIFO_DEPTH = 2;
   localparam int BUDGET     = 2000;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          start;
   logic [AW-1:0] base;
   logic [AW:0]   len;
   logic          busy;
   logic          done;
   logic          rom_re;
   logic [AW-1:0] rom_addr;
   logic [DW-1:0] rom_data = '0;
   logic          m_valid;
   logic [DW-1:0] m_data;
   logic          m_ready = 1'b1;

   rom_stream_reader #(.AW(AW), .DW(DW), .FIFO_DEPTH(FIFO_DEPTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .base(base), .len(len),
      .busy(busy), .done(done), .rom_re(rom_re), .rom_addr(rom_addr),
      .rom_data(rom_data), .m_valid(m_valid), .m_data(m_data), .m_ready(m_ready)
   );

   always #5 clk = ~clk;

   // ROM contents: one-hot walk in the lower half, thermometer fill in the upper half.
   function automatic logic [7:0] rom_fn(input int a);
      int x;
      x = a % c_ROM_DEPTH;
      if (x < 8) return 8'(1 << x);
      return 8'((1 << (x - 7)) - 1);
   endfunction

   always @(posedge clk) if (rom_re) rom_data <= rom_fn(int'(rom_addr));

   int ready_pct = 100;
   always @(posedge clk) begin
      #1;
      m_ready = ($urandom_range(0, 99) < ready_pct);
   end

   int n_vec = 0, n_miss = 0;
   int cyc = 0;
   logic [7:0] exp_q[$];
   int addr_q[$];
   int seen_v, first_v, last_v, n_vcyc, n_acc, done_cnt, done_cyc, n_re;
   logic [7:0] first_b, last_b, prev_data;
   bit prev_stall = 0, prev_busy = 0, exp_prev_busy = 0;

   always @(negedge clk) begin
      logic [7:0] e;
      cyc++;
      if (!rst_n) begin
         prev_stall = 0;
         prev_busy  = 0;
      end else begin
         if (rom_re) begin
            n_vec++; n_re++;
            addr_q.push_back(int'(rom_addr));
            if (!busy) begin n_miss++; $display("FAIL rom_re_idle: busy=%0b want 1", busy); end
         end
         n_vec++;
         if (dut.u_fifo.o_count > FIFO_DEPTH) begin
            n_miss++; $display("FAIL fifo_bound: count=%0d want <=%0d", dut.u_fifo.o_count, FIFO_DEPTH);
         end
         if (prev_stall) begin
            n_vec++;
            if (!m_valid || m_data !== prev_data) begin
               n_miss++; $display("FAIL stall_hold: v=%0b d=%h want v=1 d=%h", m_valid, m_data, prev_data);
            end
         end
         if (m_valid) begin
            if (!seen_v) first_v = cyc;
            seen_v = 1; last_v = cyc; n_vcyc++;
         end
         if (m_valid && m_ready) begin
            n_vec++;
            if (exp_q.size() == 0) begin
               n_miss++; $display("FAIL stray_byte: got %h want none", m_data);
            end else begin
               e = exp_q.pop_front();
               if (m_data !== e) begin n_miss++; $display("FAIL byte: got %h want %h", m_data, e); end
            end
            if (n_acc == 0) first_b = m_data;
            last_b = m_data;
            n_acc++;
         end
         if (done) begin
            done_cnt++; done_cyc = cyc; n_vec++;
            if (busy !== 1'b0 || prev_busy !== exp_prev_busy) begin
               n_miss++;
               $display("FAIL done_busy: busy=%0b prev=%0b want 0/%0b", busy, prev_busy, exp_prev_busy);
            end
         end
         prev_stall = m_valid && !m_ready;
         prev_data  = m_data;
         prev_busy  = busy;
      end
   end

   task automatic arm();
      seen_v = 0; n_vcyc = 0; n_acc = 0; done_cnt = 0; n_re = 0; done_cyc = -1;
      addr_q.delete();
   endtask

   task automatic check(input string name, input int got, input int want);
      n_vec++;
      if (got != want) begin n_miss++; $display("FAIL %s: got %0h want %0h", name, got, want); end
   endtask

   task automatic run_xfer(input int b, input int l, input int pct, input bit poke,
                           output logic [7:0] fb, output logic [7:0] lb);
      int t0, k;
      bit ok;
      arm();
      exp_prev_busy = (l != 0);
      for (int i = 0; i < l; i++) exp_q.push_back(rom_fn(b + i));
      ready_pct = pct;
      @(posedge clk); #1;
      start = 1'b1; base = AW'(b); len = (AW + 1)'(l);
      @(posedge clk);
      t0 = cyc + 1;
      #1 start = 1'b0;
      if (poke) begin
         repeat (3) @(posedge clk);
         #1 start = 1'b1; base = AW'(b + 5); len = (AW + 1)'(3);
         @(posedge clk);
         #1 start = 1'b0;
      end
      for (k = 0; k < BUDGET && !(done_cnt > 0 && exp_q.size() == 0); k++) begin
         @(negedge clk); #1;
      end
      n_vec++;
      if (k >= BUDGET) begin
         n_miss++;
         $display("FAIL timeout: base=%0d len=%0d left=%0d done=%0d", b, l, exp_q.size(), done_cnt);
         exp_q.delete();
         rst_n = 1'b0; @(posedge clk); #1 rst_n = 1'b1;
      end
      repeat (3) begin @(negedge clk); #1; end
      check("done_count", done_cnt, 1);
      check("rom_re_count", n_re, l);
      if (l == 0) begin
         check("len0_done_cycle", done_cyc - t0, 0);
      end else begin
         check("first_latency", seen_v ? first_v - t0 : -1, 2);
         ok = (addr_q.size() == l);
         for (int i = 0; i < l && ok; i++) if (addr_q[i] != (b + i) % c_ROM_DEPTH) ok = 0;
         check("addr_seq", int'(ok), 1);
         if (pct == 100) check("contiguous", (n_vcyc == l && last_v - first_v + 1 == l) ? 1 : 0, 1);
      end
      fb = first_b; lb = last_b;
   endtask

   typedef struct {
      int         b;
      int         l;
      int         pct;
      bit         poke;
      logic [7:0] exp_first;
      logic [7:0] exp_last;
   } vec_t;

   vec_t tbl[6];
   int   pcts[4] = '{100, 60, 40, 15};

   initial begin
      #900000;
      $display("FAIL watchdog: sim time %0t exceeded", $time);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [7:0] fb, lb;
      int b, l, k;
      tbl[0] = '{0,  16, 100, 1'b0, 8'h01, 8'hFF};
      tbl[1] = '{14, 4,  100, 1'b0, 8'h7F, 8'h02};
      tbl[2] = '{4,  8,  40,  1'b0, 8'h10, 8'h0F};
      tbl[3] = '{7,  0,  100, 1'b0, 8'h00, 8'h00};
      tbl[4] = '{3,  5,  100, 1'b1, 8'h08, 8'h80};
      tbl[5] = '{15, 16, 70,  1'b0, 8'hFF, 8'h7F};

      rst_n = 1'b0; start = 1'b1; base = '0; len = 5'd2;
      repeat (3) begin
         @(negedge clk); #1;
         check("reset_outs", {busy, done, rom_re, m_valid}, 0);
      end
      check("reset_mdata", int'(m_data), 0);
      @(posedge clk); #1;
      rst_n = 1'b1; start = 1'b0;

      run_xfer(0, 2, 100, 0, fb, lb);
      check("post_reset_bytes", {fb, lb}, 16'h0102);

      for (int i = 0; i < 6; i++) begin
         run_xfer(tbl[i].b, tbl[i].l, tbl[i].pct, tbl[i].poke, fb, lb);
         if (tbl[i].l > 0) check($sformatf("vec%0d_first_last", i), {fb, lb},
                                 {tbl[i].exp_first, tbl[i].exp_last});
      end

      // Reset mid-transfer after the fifth byte has been taken.
      arm();
      exp_prev_busy = 1;
      for (int i = 0; i < 16; i++) exp_q.push_back(rom_fn(i));
      ready_pct = 100;
      @(posedge clk); #1 start = 1'b1; base = '0; len = 5'd16;
      @(posedge clk); #1 start = 1'b0;
      for (k = 0; k < BUDGET && n_acc < 5; k++) begin @(negedge clk); #1; end
      check("midreset_reach5", n_acc, 5);
      rst_n = 1'b0;
      @(posedge clk); @(negedge clk); #1;
      check("midreset_outs", {busy, done, rom_re, m_valid}, 0);
      exp_q.delete();
      rst_n = 1'b1;
      arm();
      repeat (20) begin @(negedge clk); #1; end
      check("midreset_quiet", n_vcyc + done_cnt + n_re, 0);
      run_xfer(8, 2, 100, 0, fb, lb);
      check("midreset_fresh", {fb, lb}, 16'h0103);

      for (int r = 0; r < 24; r++) begin
         b = $urandom_range(0, 15);
         l = $urandom_range(0, 16);
         run_xfer(b, l, pcts[$urandom_range(0, 3)], (l >= 8) && ($urandom_range(0, 1) == 1), fb, lb);
      end

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   end

endmodule
`default_nettype wire
